player_physics: RTL
===================

# player_physics

Parametrised successor to the single-sprite motion block. Owns one player sprite's position and velocity in sub-pixel fixed point and advances them once per `frame_clk` edge. Runs a grounded/rising/falling jump state machine with gravity, variable jump height and terminal velocity. Consumes per-side blocking flags from the collision unit, clamps to screen bounds, and respawns the sprite when it falls below a kill line. Positions feed the sprite renderer and the collision unit.

## Interface
- `POS_W`, 10: integer pixel width of X/Y.
- `FRAC`, 4: fractional bits of position and velocity.
- `VEL_W`, 10: signed velocity width, in 1/2^FRAC px/frame.
- `SIZE`, 16: sprite edge length in px.
- `RUN_SPEED`, 32: horizontal speed (2 px/frame).
- `JUMP_V`, 64: initial upward speed (4 px/frame).
- `GRAVITY`, 4: normal downward acceleration per frame.
- `GRAVITY_HOLD`, 2: rise acceleration while jump is held.
- `HOLD_MAX`, 8: maximum number of frames for reduced gravity.
- `MAX_FALL`, 96: terminal downward speed.
- `X_MIN`, 0; `X_MAX`, 639; `Y_MIN`, 0: screen bounds in px.
- `KILL_Y`, 480: respawn threshold in px.
- `SPAWN_X`, 50; `SPAWN_Y`, 50: reset and respawn position.
- `KEY_LEFT`, 8'h04; `KEY_RIGHT`, 8'h07; `KEY_DOWN`, 8'h16; `KEY_JUMP`, 8'h1A.

Ports:
- `frame_clk`, in, 1: the single clock; one edge per video frame.
- `Reset`, in, 1: asynchronous, active-high.
- `keycode`, in, 8: current USB keycode.
- `blocked_up`, `blocked_down`, `blocked_left`, `blocked_right`, in, 1 each: the collision unit asserts these for the current registered position.
- `pos_x`, `pos_y`, out, POS_W: integer pixel of the sprite's top-left corner.
- `size`, out, POS_W: constant `SIZE`.
- `vel_y`, out, VEL_W: signed vertical velocity.
- `motion_state`, out, 2: 0 = GROUND, 1 = RISE, 2 = FALL.
- `on_ground`, out, 1: high exactly when the state is GROUND.
- `facing_left`, out, 1: last horizontal direction pressed.
- `respawn_pulse`, out, 1: one frame high on respawn.

## Operation
- Internal position is `POS_W+FRAC` bits unsigned per axis, computed at `POS_W+FRAC+1` bits signed to detect underflow.
- `pos_x`/`pos_y` are the integer bits of the registered position.
- Horizontal velocity is not stored. vx = −RUN_SPEED on KEY_LEFT with !blocked_left; +RUN_SPEED on KEY_RIGHT with !blocked_right; otherwise 0.
- `facing_left` is set by KEY_LEFT and cleared by KEY_RIGHT, regardless of blocking.
- State machine, evaluated every frame:
  - GROUND:
    - vy = 0.
    - KEY_JUMP with !blocked_up → RISE, vy = −JUMP_V, hold_cnt = 0.
    - Else !blocked_down → FALL, vy = 0.
  - RISE:
    - g = GRAVITY_HOLD if KEY_JUMP is held and hold_cnt < HOLD_MAX; otherwise g = GRAVITY. hold_cnt increments, saturating at HOLD_MAX.
    - Releasing the key permanently ends the hold for this jump.
    - vy += g.
    - blocked_up → vy = 0, FALL.
    - vy ≥ 0 → FALL.
  - FALL:
    - vy = min(vy + g, MAX_FALL), with g = 2·GRAVITY on KEY_DOWN, else GRAVITY.
    - blocked_down → GROUND, vy = 0, Y fraction cleared to 0.
- Position update: pos ← pos + v, using the velocity computed this frame (new value, not the previous one).
- X clamp: if the result is < X_MIN·2^FRAC, set it to X_MIN; if it is > (X_MAX+1−SIZE)·2^FRAC, set it to that limit. Fraction is 0 after a clamp.
- Y underflow: if the result is < Y_MIN, set Y = Y_MIN, vy = 0, and go to FALL (treated as hitting the ceiling).
- Respawn: if the integer Y of the new position is > KILL_Y:
  - position ← (SPAWN_X, SPAWN_Y), fraction 0;
  - vy = 0, state = FALL;
  - `respawn_pulse` = 1 for that frame.
  - Respawn overrides every other update.
- Simultaneous-event priority: respawn > blocking flags > key inputs.
- In GROUND with both jump and !blocked_down, jump wins.

## Timing
- All outputs are registered and change only on the `frame_clk` rising edge, or immediately on `Reset`.
- Inputs are sampled at edge N; the resulting position is visible after edge N, giving 1 frame of latency.
- Reset values:
  - `pos_x` = SPAWN_X, `pos_y` = SPAWN_Y;
  - `vel_y` = 0, `motion_state` = FALL (2);
  - `on_ground` = 0, `facing_left` = 0, `respawn_pulse` = 0;
  - hold_cnt = 0.
- Reset asserted mid-jump returns all of the above immediately; no partial state survives.
- There is no handshake. The collision flags must be valid for the current `pos_x`/`pos_y` before the next edge. The collision unit runs on faster clocks and meets this within one frame.

## Test plan
- Reset, then 1 frame with blocked_down = 0, no key → pos = (50,50), state FALL. vy = 4 after frame 1, 8 after frame 2, and saturates at 96.
- Grounded at Y = 100 with blocked_down held; KEY_JUMP for 1 frame, then release:
  - Y = 96 after the first frame;
  - vy reaches 0 on frame 17, giving apex Y = 66, then state FALL.
- Same as the previous case but KEY_JUMP held for 30 frames → apex strictly above 66 (smaller Y). Reduced gravity applies for exactly 8 frames.
- KEY_RIGHT held from X = 620 → X steps by 2 per frame and clamps at 624, then holds there. `facing_left` = 0.
- Falling sprite with KEY_LEFT held and blocked_left = 1 → X unchanged, `facing_left` = 1, Y keeps falling.
- Fall to Y > 480 → next frame pos = (50,50), `respawn_pulse` high for exactly 1 frame, vy = 0. Asserting Reset mid-rise gives reset values at once.

Source files
------------

// File: rtl/player_physics_if.sv
// player_physics_if: groups the keyboard/collision inputs and the motion
// outputs of one player sprite.
//   master: drives keycode and the four blocked_* flags, observes the motion outputs
//   slave : the physics block; consumes the inputs and drives
//           pos_x, pos_y, size, vel_y, motion_state, on_ground,
//           facing_left, respawn_pulse
interface player_physics_if #(
  parameter int POS_W = 10,
  parameter int VEL_W = 10
);
  logic [7:0]              keycode;
  logic                    blocked_up;
  logic                    blocked_down;
  logic                    blocked_left;
  logic                    blocked_right;
  logic [POS_W-1:0]        pos_x;
  logic [POS_W-1:0]        pos_y;
  logic [POS_W-1:0]        size;
  logic signed [VEL_W-1:0] vel_y;
  logic [1:0]              motion_state;
  logic                    on_ground;
  logic                    facing_left;
  logic                    respawn_pulse;

  modport master (
    output keycode, blocked_up, blocked_down, blocked_left, blocked_right,
    input  pos_x, pos_y, size, vel_y, motion_state, on_ground, facing_left,
           respawn_pulse
  );

  modport slave (
    input  keycode, blocked_up, blocked_down, blocked_left, blocked_right,
    output pos_x, pos_y, size, vel_y, motion_state, on_ground, facing_left,
           respawn_pulse
  );
endinterface

// File: rtl/player_physics.sv
// player_physics: position/velocity integrator for one player sprite.
// Advances a sub-pixel fixed-point position once per frame_clk edge, runs a
// GROUND/RISE/FALL jump machine with gravity, variable jump height and
// terminal velocity, honours collision blocking flags, clamps to the screen
// and respawns the sprite when it drops below the kill line.
// Ports:
//   frame_clk : one rising edge per video frame
//   Reset     : asynchronous, active-high
//   bus       : player_physics_if.slave (keycode, blocked_* in; pos_x, pos_y,
//               size, vel_y, motion_state, on_ground, facing_left,
//               respawn_pulse out)
module player_physics #(
  parameter int POS_W        = 10,
  parameter int FRAC         = 4,
  parameter int VEL_W        = 10,
  parameter int SIZE         = 16,
  parameter int RUN_SPEED    = 32,
  parameter int JUMP_V       = 64,
  parameter int GRAVITY      = 4,
  parameter int GRAVITY_HOLD = 2,
  parameter int HOLD_MAX     = 8,
  parameter int MAX_FALL     = 96,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int KILL_Y       = 480,
  parameter int SPAWN_X      = 50,
  parameter int SPAWN_Y      = 50,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_DOWN  = 8'h16,
  parameter logic [7:0] KEY_JUMP  = 8'h1A
) (
  input logic             frame_clk,
  input logic             Reset,
  player_physics_if.slave bus
);
  localparam int PW = POS_W + FRAC;  // stored position width
  localparam int SW = PW + 1;        // signed working width (catches underflow)
  localparam int HW = $clog2(HOLD_MAX + 1);

  localparam logic signed [SW-1:0] X_LO = SW'(X_MIN * (2 ** FRAC));
  localparam logic signed [SW-1:0] X_HI = SW'((X_MAX + 1 - SIZE) * (2 ** FRAC));
  localparam logic signed [SW-1:0] Y_LO = SW'(Y_MIN * (2 ** FRAC));
  localparam logic [PW-1:0]        SPAWN_XF = PW'(SPAWN_X * (2 ** FRAC));
  localparam logic [PW-1:0]        SPAWN_YF = PW'(SPAWN_Y * (2 ** FRAC));
  localparam logic [POS_W-1:0]     KILL_LIM = POS_W'(KILL_Y);

  localparam logic signed [VEL_W-1:0] V_RUN  = VEL_W'(RUN_SPEED);
  localparam logic signed [VEL_W-1:0] V_JUMP = VEL_W'(JUMP_V);
  localparam logic signed [VEL_W-1:0] V_G    = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] V_G2   = VEL_W'(2 * GRAVITY);
  localparam logic signed [VEL_W-1:0] V_GH   = VEL_W'(GRAVITY_HOLD);
  localparam logic signed [VEL_W-1:0] V_MAX  = VEL_W'(MAX_FALL);
  localparam logic [HW-1:0]           HOLD_LIM = HW'(HOLD_MAX);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [PW-1:0]           x, x_next, y, y_next, y_base;
  logic signed [VEL_W-1:0] vy, vy_next, vy_sum, vx, g;
  logic [HW-1:0]           hold_cnt, hold_next;
  logic                    facing, facing_next, pulse, pulse_next;
  logic                    clear_frac;
  logic signed [SW-1:0]    x_sum, y_sum;
  logic                    key_left, key_right, key_down, key_jump;

  assign key_left  = (bus.keycode == KEY_LEFT);
  assign key_right = (bus.keycode == KEY_RIGHT);
  assign key_down  = (bus.keycode == KEY_DOWN);
  assign key_jump  = (bus.keycode == KEY_JUMP);

  always_comb begin
    state_next  = state;
    vy_next     = vy;
    vy_sum      = vy;
    hold_next   = hold_cnt;
    facing_next = facing;
    pulse_next  = 1'b0;
    clear_frac  = 1'b0;
    g           = V_G;
    vx          = '0;

    // Horizontal speed is derived fresh each frame, never stored.
    if (key_left && !bus.blocked_left) begin
      vx = -V_RUN;
    end else if (key_right && !bus.blocked_right) begin
      vx = V_RUN;
    end
    if (key_left) begin
      facing_next = 1'b1;
    end else if (key_right) begin
      facing_next = 1'b0;
    end

    case (state)
      GROUND: begin
        vy_next = '0;
        if (key_jump && !bus.blocked_up) begin
          state_next = RISE;
          vy_next    = -V_JUMP;
          hold_next  = '0;
        end else if (!bus.blocked_down) begin
          state_next = FALL;
        end
      end
      RISE: begin
        // Letting go saturates the counter, so the hold cannot resume later
        // in the same jump even if the key is pressed again.
        if (!key_jump) begin
          hold_next = HOLD_LIM;
        end else if (hold_cnt < HOLD_LIM) begin
          hold_next = hold_cnt + 1'b1;
          g         = V_GH;
        end
        vy_next = vy + g;
        if (bus.blocked_up) begin
          vy_next    = '0;
          state_next = FALL;
        end else if (!vy_next[VEL_W-1]) begin
          state_next = FALL;
        end
      end
      default: begin  // FALL
        g       = key_down ? V_G2 : V_G;
        vy_sum  = vy + g;
        vy_next = (vy_sum > V_MAX) ? V_MAX : vy_sum;
        if (bus.blocked_down) begin
          vy_next    = '0;
          state_next = GROUND;
          clear_frac = 1'b1;
        end
      end
    endcase

    // Integrate with this frame's velocity.
    x_sum = $signed({1'b0, x}) + SW'(vx);
    if (x_sum < X_LO) begin
      x_next = X_LO[PW-1:0];
    end else if (x_sum > X_HI) begin
      x_next = X_HI[PW-1:0];
    end else begin
      x_next = x_sum[PW-1:0];
    end

    y_base = clear_frac ? {y[PW-1:FRAC], {FRAC{1'b0}}} : y;
    y_sum  = $signed({1'b0, y_base}) + SW'(vy_next);
    if (y_sum < Y_LO) begin
      // Running off the top of the screen behaves like a ceiling hit.
      y_next     = Y_LO[PW-1:0];
      vy_next    = '0;
      state_next = FALL;
    end else begin
      y_next = y_sum[PW-1:0];
    end

    // Respawn wins over everything computed above, including facing.
    if (y_next[PW-1:FRAC] > KILL_LIM) begin
      x_next      = SPAWN_XF;
      y_next      = SPAWN_YF;
      vy_next     = '0;
      state_next  = FALL;
      facing_next = facing;
      pulse_next  = 1'b1;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x        <= SPAWN_XF;
      y        <= SPAWN_YF;
      vy       <= '0;
      state    <= FALL;
      hold_cnt <= '0;
      facing   <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      x        <= x_next;
      y        <= y_next;
      vy       <= vy_next;
      state    <= state_next;
      hold_cnt <= hold_next;
      facing   <= facing_next;
      pulse    <= pulse_next;
    end
  end

  assign bus.pos_x         = x[PW-1:FRAC];
  assign bus.pos_y         = y[PW-1:FRAC];
  assign bus.size          = POS_W'(SIZE);
  assign bus.vel_y         = vy;
  assign bus.motion_state  = state;
  assign bus.on_ground     = (state == GROUND);
  assign bus.facing_left   = facing;
  assign bus.respawn_pulse = pulse;
endmodule
